// File: rtl/axi_lite_arbiter_2x1.sv
// Two-master, one-slave AXI4-Lite arbiter. Read and write paths are arbitrated
// independently, with round-robin grant and one outstanding transaction per path.
module axi_lite_arbiter_2x1 #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESETN,
    // Master 0
    input  logic [ADDR_WIDTH-1:0]   M0_AXI_AWADDR,
    input  logic [2:0]              M0_AXI_AWPROT,
    input  logic                    M0_AXI_AWVALID,
    output logic                    M0_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   M0_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] M0_AXI_WSTRB,
    input  logic                    M0_AXI_WVALID,
    output logic                    M0_AXI_WREADY,
    output logic [1:0]              M0_AXI_BRESP,
    output logic                    M0_AXI_BVALID,
    input  logic                    M0_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   M0_AXI_ARADDR,
    input  logic [2:0]              M0_AXI_ARPROT,
    input  logic                    M0_AXI_ARVALID,
    output logic                    M0_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   M0_AXI_RDATA,
    output logic [1:0]              M0_AXI_RRESP,
    output logic                    M0_AXI_RVALID,
    input  logic                    M0_AXI_RREADY,
    // Master 1
    input  logic [ADDR_WIDTH-1:0]   M1_AXI_AWADDR,
    input  logic [2:0]              M1_AXI_AWPROT,
    input  logic                    M1_AXI_AWVALID,
    output logic                    M1_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   M1_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] M1_AXI_WSTRB,
    input  logic                    M1_AXI_WVALID,
    output logic                    M1_AXI_WREADY,
    output logic [1:0]              M1_AXI_BRESP,
    output logic                    M1_AXI_BVALID,
    input  logic                    M1_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   M1_AXI_ARADDR,
    input  logic [2:0]              M1_AXI_ARPROT,
    input  logic                    M1_AXI_ARVALID,
    output logic                    M1_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   M1_AXI_RDATA,
    output logic [1:0]              M1_AXI_RRESP,
    output logic                    M1_AXI_RVALID,
    input  logic                    M1_AXI_RREADY,
    // Slave
    output logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    output logic [2:0]              S_AXI_AWPROT,
    output logic                    S_AXI_AWVALID,
    input  logic                    S_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    output logic                    S_AXI_WVALID,
    input  logic                    S_AXI_WREADY,
    input  logic [1:0]              S_AXI_BRESP,
    input  logic                    S_AXI_BVALID,
    output logic                    S_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    output logic [2:0]              S_AXI_ARPROT,
    output logic                    S_AXI_ARVALID,
    input  logic                    S_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    input  logic [1:0]              S_AXI_RRESP,
    input  logic                    S_AXI_RVALID,
    output logic                    S_AXI_RREADY
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_e;

    rd_state_e r_rd_state;
    logic      r_rd_gnt;   // 0: M0, 1: M1
    logic      r_rd_ptr;   // master that wins a tie
    wr_state_e r_wr_state;
    logic      r_wr_gnt;
    logic      r_wr_ptr;
    logic      r_aw_done;
    logic      r_w_done;

    logic w_rd_pick, w_wr_pick, w_wr_req0, w_wr_req1;
    logic w_rd_addr_ph, w_rd_data_ph, w_wr_req_ph, w_wr_resp_ph;
    logic w_aw_hs, w_w_hs;

    assign w_rd_pick = (M0_AXI_ARVALID && M1_AXI_ARVALID) ? r_rd_ptr : M1_AXI_ARVALID;
    assign w_wr_req0 = M0_AXI_AWVALID | M0_AXI_WVALID;
    assign w_wr_req1 = M1_AXI_AWVALID | M1_AXI_WVALID;
    assign w_wr_pick = (w_wr_req0 && w_wr_req1) ? r_wr_ptr : w_wr_req1;

    // Reset gates the phase decodes so every handshake output is 0 while reset is held
    assign w_rd_addr_ph = AXI_ARESETN && (r_rd_state == R_ADDR);
    assign w_rd_data_ph = AXI_ARESETN && (r_rd_state == R_DATA);
    assign w_wr_req_ph  = AXI_ARESETN && (r_wr_state == W_REQ);
    assign w_wr_resp_ph = AXI_ARESETN && (r_wr_state == W_RESP);

    assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID & S_AXI_WREADY;

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            r_rd_state <= R_IDLE;
            r_rd_gnt   <= 1'b0;
            r_rd_ptr   <= 1'b0;
        end else begin
            unique case (r_rd_state)
                R_IDLE: if (M0_AXI_ARVALID || M1_AXI_ARVALID) begin
                    r_rd_gnt   <= w_rd_pick;
                    r_rd_state <= R_ADDR;
                end
                R_ADDR: if (S_AXI_ARVALID && S_AXI_ARREADY) r_rd_state <= R_DATA;
                R_DATA: if (S_AXI_RVALID && S_AXI_RREADY) begin
                    r_rd_ptr   <= ~r_rd_gnt;
                    r_rd_state <= R_IDLE;
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            r_wr_state <= W_IDLE;
            r_wr_gnt   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            unique case (r_wr_state)
                W_IDLE: if (w_wr_req0 || w_wr_req1) begin
                    r_wr_gnt   <= w_wr_pick;
                    r_aw_done  <= 1'b0;
                    r_w_done   <= 1'b0;
                    r_wr_state <= W_REQ;
                end
                W_REQ: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_wr_state <= W_RESP;
                end
                W_RESP: if (S_AXI_BVALID && S_AXI_BREADY) begin
                    r_wr_ptr   <= ~r_wr_gnt;
                    r_wr_state <= W_IDLE;
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    // Read path routing
    assign S_AXI_ARADDR  = w_rd_addr_ph ? (r_rd_gnt ? M1_AXI_ARADDR : M0_AXI_ARADDR) : '0;
    assign S_AXI_ARPROT  = w_rd_addr_ph ? (r_rd_gnt ? M1_AXI_ARPROT : M0_AXI_ARPROT) : '0;
    assign S_AXI_ARVALID = w_rd_addr_ph & (r_rd_gnt ? M1_AXI_ARVALID : M0_AXI_ARVALID);
    assign M0_AXI_ARREADY = w_rd_addr_ph & ~r_rd_gnt & S_AXI_ARREADY;
    assign M1_AXI_ARREADY = w_rd_addr_ph &  r_rd_gnt & S_AXI_ARREADY;

    assign M0_AXI_RDATA  = (w_rd_data_ph && !r_rd_gnt) ? S_AXI_RDATA : '0;
    assign M0_AXI_RRESP  = (w_rd_data_ph && !r_rd_gnt) ? S_AXI_RRESP : '0;
    assign M0_AXI_RVALID = w_rd_data_ph & ~r_rd_gnt & S_AXI_RVALID;
    assign M1_AXI_RDATA  = (w_rd_data_ph && r_rd_gnt) ? S_AXI_RDATA : '0;
    assign M1_AXI_RRESP  = (w_rd_data_ph && r_rd_gnt) ? S_AXI_RRESP : '0;
    assign M1_AXI_RVALID = w_rd_data_ph & r_rd_gnt & S_AXI_RVALID;
    assign S_AXI_RREADY  = w_rd_data_ph & (r_rd_gnt ? M1_AXI_RREADY : M0_AXI_RREADY);

    // Write path routing; a channel already handshaken is masked off
    assign S_AXI_AWADDR  = w_wr_req_ph ? (r_wr_gnt ? M1_AXI_AWADDR : M0_AXI_AWADDR) : '0;
    assign S_AXI_AWPROT  = w_wr_req_ph ? (r_wr_gnt ? M1_AXI_AWPROT : M0_AXI_AWPROT) : '0;
    assign S_AXI_AWVALID = w_wr_req_ph & ~r_aw_done &
                           (r_wr_gnt ? M1_AXI_AWVALID : M0_AXI_AWVALID);
    assign M0_AXI_AWREADY = w_wr_req_ph & ~r_wr_gnt & ~r_aw_done & S_AXI_AWREADY;
    assign M1_AXI_AWREADY = w_wr_req_ph &  r_wr_gnt & ~r_aw_done & S_AXI_AWREADY;

    assign S_AXI_WDATA   = w_wr_req_ph ? (r_wr_gnt ? M1_AXI_WDATA : M0_AXI_WDATA) : '0;
    assign S_AXI_WSTRB   = w_wr_req_ph ? (r_wr_gnt ? M1_AXI_WSTRB : M0_AXI_WSTRB) : '0;
    assign S_AXI_WVALID  = w_wr_req_ph & ~r_w_done &
                           (r_wr_gnt ? M1_AXI_WVALID : M0_AXI_WVALID);
    assign M0_AXI_WREADY = w_wr_req_ph & ~r_wr_gnt & ~r_w_done & S_AXI_WREADY;
    assign M1_AXI_WREADY = w_wr_req_ph &  r_wr_gnt & ~r_w_done & S_AXI_WREADY;

    assign M0_AXI_BRESP  = (w_wr_resp_ph && !r_wr_gnt) ? S_AXI_BRESP : '0;
    assign M0_AXI_BVALID = w_wr_resp_ph & ~r_wr_gnt & S_AXI_BVALID;
    assign M1_AXI_BRESP  = (w_wr_resp_ph && r_wr_gnt) ? S_AXI_BRESP : '0;
    assign M1_AXI_BVALID = w_wr_resp_ph & r_wr_gnt & S_AXI_BVALID;
    assign S_AXI_BREADY  = w_wr_resp_ph & (r_wr_gnt ? M1_AXI_BREADY : M0_AXI_BREADY);

endmodule
